// File: rtl/inst_fetch_unit.sv
// Fetch stage: keeps the fetch PC, issues one instruction-memory read at a time,
// and holds the returned word in a valid/ready output register for imm_gen and the decoder.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  func3
);

  // WAIT: response still wanted; DROP: response outstanding but made stale by a redirect
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        slot_free;
  logic        load;
  logic [31:0] redir_tgt;

  assign slot_free = !inst_valid_q || inst_ready;
  assign redir_tgt = redirect_pc & ~32'h3;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    imem_req = 1'b0;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          pc_d = redir_tgt;
        end else if (slot_free) begin
          imem_req = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid && !redirect_valid) begin
          load    = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = IDLE;
        end else if (imem_rvalid) begin
          pc_d    = redir_tgt;
          state_d = IDLE;
        end else if (redirect_valid) begin
          pc_d    = redir_tgt;
          state_d = DROP;
        end
      end
      DROP: begin
        if (redirect_valid) pc_d = redir_tgt;
        if (imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Redirect beats a load, which beats a consume.
  always_comb begin
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    if (inst_valid_q && inst_ready) begin
      inst_valid_d = 1'b0;
      inst_d       = NOP_INST;
    end
    if (load) begin
      inst_valid_d = 1'b1;
      inst_d       = imem_rdata;
      inst_pc_d    = pc_q;
    end
    if (redirect_valid) begin
      inst_valid_d = 1'b0;
      inst_d       = NOP_INST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_q       <= NOP_INST;
      inst_pc_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  assign imem_addr  = pc_q & ~32'h3;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign opcode     = inst_q[6:0];
  assign func3      = inst_q[14:12];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios with literal expectations, then random
// traffic against a per-cycle behavioural model and a variable-latency memory model.
module tb_inst_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic [2:0]  func3;

  inst_fetch_unit #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .opcode(opcode), .func3(func3)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // memory contents: two fixed words, everything else a hash of the address
  function automatic logic [31:0] resp_data(logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    if (a == 32'h104) return 32'h00A0_0113;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // memory model state
  int          lat_min = 1, lat_max = 1;
  bit          spur_en = 1'b0;
  int          mem_cnt = -1;
  logic [31:0] mem_addr;
  logic        nxt_rvalid = 1'b0;
  logic [31:0] nxt_rdata  = '0;

  // behavioural model: m_out 0 = nothing outstanding, 1 = wanted, 2 = stale
  bit          m_known = 1'b0;
  logic [31:0] m_pc, m_inst, m_ipc;
  bit          m_valid;
  int          m_out;

  always @(negedge clk) begin
    bit free, ereq, cons, ld;
    free = !m_valid || inst_ready;
    ereq = (m_out == 0) && free && !redirect_valid;
    if (m_known) begin
      check("imem_req", {31'b0, imem_req}, {31'b0, ereq});
      if (ereq) check("imem_addr", imem_addr, m_pc);
      check("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
      check("inst", inst, m_inst);
      check("opcode", {25'b0, opcode}, {25'b0, m_inst[6:0]});
      check("func3", {29'b0, func3}, {29'b0, m_inst[14:12]});
      if (m_valid) check("inst_pc", inst_pc, m_ipc);
    end
    if (rst) begin
      m_known = 1'b1; m_pc = RPC; m_out = 0;
      m_valid = 1'b0; m_inst = NOP; m_ipc = '0;
    end else if (m_known) begin
      cons = m_valid && inst_ready;
      ld   = (m_out == 1) && imem_rvalid && !redirect_valid;
      if (cons) begin m_valid = 1'b0; m_inst = NOP; end
      if (ld) begin
        m_valid = 1'b1; m_inst = imem_rdata; m_ipc = m_pc; m_pc = m_pc + 32'd4;
      end
      if (m_out != 0 && imem_rvalid) m_out = 0;
      if (redirect_valid) begin
        m_pc = redirect_pc & ~32'h3; m_valid = 1'b0; m_inst = NOP;
        if (m_out == 1) m_out = 2;
      end
      if (ereq) m_out = 1;
    end
    // memory: schedule the response for a later cycle, or an occasional stray rvalid
    nxt_rvalid = 1'b0;
    nxt_rdata  = $urandom;
    if (rst) begin
      mem_cnt = -1;
    end else begin
      if (imem_req && mem_cnt < 0) begin
        mem_addr = imem_addr;
        mem_cnt  = $urandom_range(lat_max, lat_min) - 1;
      end else if (mem_cnt > 0) begin
        mem_cnt--;
      end
      if (mem_cnt == 0) begin
        nxt_rvalid = 1'b1; nxt_rdata = resp_data(mem_addr); mem_cnt = -1;
      end else if (mem_cnt < 0 && spur_en && $urandom_range(9, 0) == 0) begin
        nxt_rvalid = 1'b1;
      end
    end
  end

  task automatic cycle(input bit r, input bit rv, input logic [31:0] rp, input bit rdy);
    @(posedge clk); #1;
    rst = r; redirect_valid = rv; redirect_pc = rp; inst_ready = rdy;
    imem_rvalid = nxt_rvalid; imem_rdata = nxt_rdata;
    @(negedge clk); #1;
  endtask

  initial begin
    // reset and first request
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst", inst, NOP);
    cycle(0, 0, 0, 1);
    check("first_req", {31'b0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h100);
    cycle(0, 0, 0, 1);
    check("wait_noreq", {31'b0, imem_req}, 32'd0);
    // sequential fetch, 1-cycle latency
    cycle(0, 0, 0, 1);
    check("w0_inst", inst, 32'h0050_0093);
    check("w0_pc", inst_pc, 32'h100);
    check("w0_opcode", {25'b0, opcode}, 32'h13);
    check("w0_func3", {29'b0, func3}, 32'd0);
    check("w1_req", {31'b0, imem_req}, 32'd1);
    check("w1_addr", imem_addr, 32'h104);
    cycle(0, 0, 0, 1);
    check("w1_wait_valid", {31'b0, inst_valid}, 32'd0);
    // backpressure on the second word
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0);
      check("bp_req", {31'b0, imem_req}, 32'd0);
      check("bp_inst", inst, 32'h00A0_0113);
      check("bp_pc", inst_pc, 32'h104);
    end
    lat_max = 2; lat_min = 2;
    cycle(0, 0, 0, 1);
    check("bp_release_req", {31'b0, imem_req}, 32'd1);
    check("bp_release_addr", imem_addr, 32'h108);
    // redirect while waiting -> stale response dropped
    cycle(0, 1, 32'h203, 1);
    check("drop_valid", {31'b0, inst_valid}, 32'd0);
    cycle(0, 0, 0, 1);
    check("drop_noreq", {31'b0, imem_req}, 32'd0);
    lat_max = 1; lat_min = 1;
    cycle(0, 0, 0, 1);
    check("redir_addr", imem_addr, 32'h200);
    check("redir_req", {31'b0, imem_req}, 32'd1);
    check("redir_valid", {31'b0, inst_valid}, 32'd0);
    // redirect coincident with rvalid
    cycle(0, 1, 32'h300, 1);
    cycle(0, 0, 0, 1);
    check("coin_valid", {31'b0, inst_valid}, 32'd0);
    check("coin_addr", imem_addr, 32'h300);
    cycle(0, 0, 0, 1);
    // redirect coincident with a consume
    cycle(0, 1, 32'h400, 1);
    check("cons_pc", inst_pc, 32'h300);
    check("cons_noreq", {31'b0, imem_req}, 32'd0);
    cycle(0, 0, 0, 1);
    check("cons_cleared", {31'b0, inst_valid}, 32'd0);
    check("cons_nop", inst, NOP);
    check("cons_addr", imem_addr, 32'h400);
    cycle(0, 0, 0, 1);
    // wrap-around
    cycle(0, 1, 32'hFFFF_FFFF, 1);
    cycle(0, 0, 0, 1);
    check("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    check("wrap_pc", inst_pc, 32'hFFFF_FFFC);
    check("wrap_next", imem_addr, 32'h0);
    // reset while a request is outstanding
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    check("midrst_req", {31'b0, imem_req}, 32'd1);
    check("midrst_addr", imem_addr, RPC);
    check("midrst_valid", {31'b0, inst_valid}, 32'd0);
    // random traffic
    lat_min = 1; lat_max = 3; spur_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] rp;
      rp = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
      cycle($urandom_range(199, 0) == 0, $urandom_range(7, 0) == 0, rp, $urandom_range(9, 0) < 7);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
